// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ word requesters.
// Each granted word is sent LSB byte first using the tx_send/tx_busy handshake.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int WORD_BYTES    = 2,
  parameter int START_TIMEOUT = 100
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ*8*WORD_BYTES-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                done_o,
  input  logic                              tx_busy_i,
  output logic                              tx_send_o,
  output logic [7:0]                        tx_data_o,
  output logic                              busy_o,
  output logic [1:0]                        active_id_o,
  output logic                              timeout_err_o
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_START, WAIT_DONE, BYTE_DONE} state_t;

  state_t          state_q;
  logic [1:0]      rr_ptr_q;
  logic [1:0]      active_id_q;
  logic [BW-1:0]   byte_idx_q;
  logic [TW-1:0]   timer_q;
  logic [W-1:0]    word_q;
  logic [3:0]      done_q;
  logic            tx_send_q;
  logic [7:0]      tx_data_q;
  logic            busy_q;
  logic            timeout_err_q;

  logic            grant_vld_d;
  logic [1:0]      grant_id_d;
  logic [2:0]      scan_idx;
  logic [3:0]      req_pad;
  logic [3:0]      done_sel;
  logic            last_byte;
  logic [1:0]      rr_next;
  logic [W-1:0]    req_word [4];

  // Unused requester slots read as idle with a zero word so indexing stays 2 bits wide.
  assign req_pad = 4'(req_i);
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    if (gi < NUM_REQ) begin : g_used
      assign req_word[gi] = req_data_i[gi*W +: W];
    end else begin : g_unused
      assign req_word[gi] = '0;
    end
  end

  // Scan from the farthest offset down so the requester nearest rr_ptr wins.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_id_d  = 2'd0;
    scan_idx    = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + 3'(k);
      if (scan_idx >= 3'(NUM_REQ)) scan_idx = scan_idx - 3'(NUM_REQ);
      if (req_pad[scan_idx[1:0]]) begin
        grant_vld_d = 1'b1;
        grant_id_d  = scan_idx[1:0];
      end
    end
  end

  assign done_sel  = 4'b0001 << active_id_q;
  assign last_byte = (byte_idx_q == BW'(WORD_BYTES - 1));
  assign rr_next   = (active_id_q == 2'(NUM_REQ - 1)) ? 2'd0 : active_id_q + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 2'd0;
      active_id_q   <= 2'd0;
      byte_idx_q    <= '0;
      timer_q       <= '0;
      word_q        <= '0;
      done_q        <= 4'd0;
      tx_send_q     <= 1'b0;
      tx_data_q     <= 8'd0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      tx_send_q <= 1'b0;
      done_q    <= 4'd0;
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            active_id_q <= grant_id_d;
            tx_data_q   <= req_word[grant_id_d][7:0];
            word_q      <= req_word[grant_id_d] >> 8;
            byte_idx_q  <= '0;
            tx_send_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          timer_q <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_busy_i) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
            // A byte the UART never acknowledged still counts as sent.
            timeout_err_q <= 1'b1;
            done_q        <= last_byte ? done_sel : 4'd0;
            state_q       <= BYTE_DONE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            done_q  <= last_byte ? done_sel : 4'd0;
            state_q <= BYTE_DONE;
          end
        end
        BYTE_DONE: begin
          if (last_byte) begin
            rr_ptr_q <= rr_next;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            byte_idx_q <= byte_idx_q + BW'(1);
            tx_data_q  <= word_q[7:0];
            word_q     <= word_q >> 8;
            tx_send_q  <= 1'b1;
            state_q    <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done_o        = done_q[NUM_REQ-1:0];
  assign tx_send_o     = tx_send_q;
  assign tx_data_o     = tx_data_q;
  assign busy_o        = busy_q;
  assign active_id_o   = active_id_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized rounds checked
// against a round-robin word-level reference model and a simple UART busy model.
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int WB = 2;
  localparam int TO = 100;
  localparam int W  = 8 * WB;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_i = '0;
  logic [NR*W-1:0] req_data_i = '0;
  logic            tx_busy_i = 1'b0;
  logic [NR-1:0]   done_o;
  logic            tx_send_o;
  logic [7:0]      tx_data_o;
  logic            busy_o;
  logic [1:0]      active_id_o;
  logic            timeout_err_o;

  uart_tx_arbiter #(.NUM_REQ(NR), .WORD_BYTES(WB), .START_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .req_data_i(req_data_i),
    .done_o(done_o), .tx_busy_i(tx_busy_i), .tx_send_o(tx_send_o),
    .tx_data_o(tx_data_o), .busy_o(busy_o), .active_id_o(active_id_o),
    .timeout_err_o(timeout_err_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // UART model: busy rises the cycle after the strobe and stays up busy_len cycles.
  int busy_len  = 10;
  bit uart_dead = 1'b0;
  bit pend      = 1'b0;
  int hold      = 0;

  always @(negedge clk) begin
    if (reset || uart_dead) begin
      tx_busy_i = 1'b0; pend = 1'b0; hold = 0;
    end else if (tx_send_o) begin
      pend = 1'b1;
    end else if (pend) begin
      tx_busy_i = 1'b1; hold = busy_len; pend = 1'b0;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) tx_busy_i = 1'b0;
    end
  end

  logic [7:0] sent_bytes[$];
  int         send_cyc[$];
  int         done_ids[$];
  int         done_cyc[$];

  task automatic clear_logs();
    sent_bytes.delete(); send_cyc.delete(); done_ids.delete(); done_cyc.delete();
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (tx_send_o) begin
      sent_bytes.push_back(tx_data_o);
      send_cyc.push_back(cyc);
      $display("[TB] cyc %0d tx_send byte %02h id %0d", cyc, tx_data_o, active_id_o);
    end
    for (int i = 0; i < NR; i++) begin
      if (done_o[i]) begin
        done_ids.push_back(i);
        done_cyc.push_back(cyc);
        $display("[TB] cyc %0d done requester %0d", cyc, i);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_i = '0; uart_dead = 1'b0;
    step(); step();
    reset = 1'b0;
    clear_logs();
  endtask

  function automatic logic [7:0] byte_of(input logic [W-1:0] w, input int b);
    return 8'((w >> (8 * b)) & 'hFF);
  endfunction

  task automatic test_reset();
    reset = 1'b1; req_i = '1; req_data_i = NR*W'($urandom);
    step(); step();
    tests++; if (done_o !== '0) begin fails++; $display("FAIL reset_done got %b want 0", done_o); end
    tests++; if (tx_send_o !== 1'b0) begin fails++; $display("FAIL reset_tx_send got %b want 0", tx_send_o); end
    tests++; if (tx_data_o !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", tx_data_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_o); end
    tests++; if (active_id_o !== 2'd0) begin fails++; $display("FAIL reset_active_id got %0d want 0", active_id_o); end
    tests++; if (timeout_err_o !== 1'b0) begin fails++; $display("FAIL reset_timeout_err got %b want 0", timeout_err_o); end
    req_i = '0;
    do_reset();
  endtask

  task automatic test_single_word();
    int c0;
    do_reset();
    busy_len = 10;
    req_data_i[W-1:0] = 16'hA55A;
    req_i = 2'b01;
    c0 = cyc;
    for (int k = 0; k < 300 && done_ids.size() == 0; k++) begin
      step();
      if (done_o[0]) req_i[0] = 1'b0;
    end
    for (int k = 0; k < 5; k++) step();
    tests++; if (done_ids.size() != 1) begin fails++; $display("FAIL single_done_count got %0d want 1", done_ids.size()); end
    tests++; if (sent_bytes.size() != 2) begin fails++; $display("FAIL single_byte_count got %0d want 2", sent_bytes.size()); end
    if (sent_bytes.size() == 2 && done_cyc.size() == 1) begin
      tests++; if (sent_bytes[0] !== 8'h5A) begin fails++; $display("FAIL single_byte0 got %h want 5a", sent_bytes[0]); end
      tests++; if (sent_bytes[1] !== 8'hA5) begin fails++; $display("FAIL single_byte1 got %h want a5", sent_bytes[1]); end
      tests++; if (send_cyc[0] != c0 + 1) begin fails++; $display("FAIL single_first_latency got %0d want %0d", send_cyc[0] - c0, 1); end
      tests++; if (send_cyc[1] - send_cyc[0] != busy_len + 3) begin fails++; $display("FAIL single_byte_gap got %0d want %0d", send_cyc[1] - send_cyc[0], busy_len + 3); end
      tests++; if (done_cyc[0] != send_cyc[1] + busy_len + 2) begin fails++; $display("FAIL single_done_time got %0d want %0d", done_cyc[0] - send_cyc[1], busy_len + 2); end
    end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL single_busy_after got %b want 0", busy_o); end
    tests++; if (timeout_err_o !== 1'b0) begin fails++; $display("FAIL single_timeout_err got %b want 0", timeout_err_o); end
  endtask

  task automatic test_contention();
    logic [7:0] exp_b[6] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    int         exp_id[3] = '{0, 1, 0};
    bit         rereq = 1'b0;
    do_reset();
    req_data_i = {16'h2222, 16'h1111};
    req_i = 2'b11;
    for (int k = 0; k < 600 && done_ids.size() < 3; k++) begin
      step();
      if (done_o[0]) begin
        if (!rereq) begin req_data_i[W-1:0] = 16'h3333; rereq = 1'b1; end
        else req_i[0] = 1'b0;
      end
      if (done_o[1]) req_i[1] = 1'b0;
    end
    step(); step();
    tests++; if (sent_bytes.size() != 6) begin fails++; $display("FAIL contention_byte_count got %0d want 6", sent_bytes.size()); end
    tests++; if (done_ids.size() != 3) begin fails++; $display("FAIL contention_done_count got %0d want 3", done_ids.size()); end
    for (int i = 0; i < 6 && i < sent_bytes.size(); i++) begin
      tests++; if (sent_bytes[i] !== exp_b[i]) begin fails++; $display("FAIL contention_byte%0d got %h want %h", i, sent_bytes[i], exp_b[i]); end
    end
    for (int i = 0; i < 3 && i < done_ids.size(); i++) begin
      tests++; if (done_ids[i] != exp_id[i]) begin fails++; $display("FAIL contention_order%0d got %0d want %0d", i, done_ids[i], exp_id[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] w;
    logic         te_first = 1'bx;
    do_reset();
    uart_dead = 1'b1;
    w = W'($urandom);
    req_data_i[W-1:0] = w;
    req_i = 2'b01;
    for (int k = 0; k < 1000 && done_ids.size() == 0; k++) begin
      step();
      if (tx_send_o && sent_bytes.size() == 1) te_first = timeout_err_o;
      if (done_o[0]) req_i[0] = 1'b0;
    end
    for (int k = 0; k < 20; k++) step();
    tests++; if (done_ids.size() != 1) begin fails++; $display("FAIL timeout_done_count got %0d want 1", done_ids.size()); end
    tests++; if (te_first !== 1'b0) begin fails++; $display("FAIL timeout_err_early got %b want 0", te_first); end
    if (sent_bytes.size() == 2 && done_cyc.size() == 1) begin
      tests++; if (send_cyc[1] - send_cyc[0] != TO + 2) begin fails++; $display("FAIL timeout_byte_gap got %0d want %0d", send_cyc[1] - send_cyc[0], TO + 2); end
      tests++; if (done_cyc[0] - send_cyc[1] != TO + 1) begin fails++; $display("FAIL timeout_done_time got %0d want %0d", done_cyc[0] - send_cyc[1], TO + 1); end
      tests++; if ({sent_bytes[1], sent_bytes[0]} !== w) begin fails++; $display("FAIL timeout_word got %h want %h", {sent_bytes[1], sent_bytes[0]}, w); end
    end else begin
      tests++; fails++; $display("FAIL timeout_bytes got %0d bytes want 2", sent_bytes.size());
    end
    tests++; if (timeout_err_o !== 1'b1) begin fails++; $display("FAIL timeout_err_sticky got %b want 1", timeout_err_o); end
    uart_dead = 1'b0;
  endtask

  // Runs straight after test_timeout: timeout_err is set and rr_ptr points at requester 1.
  task automatic test_reset_mid();
    logic [W-1:0] w0, w1;
    w0 = W'($urandom) | 16'h0101;
    w1 = W'($urandom) | 16'h0101;
    clear_logs();
    busy_len = 10;
    req_data_i = {w1, ~w1};
    req_i = 2'b10;
    for (int k = 0; k < 20 && sent_bytes.size() == 0; k++) step();
    step(); step(); step();
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL midreset_busy_before got %b want 1", busy_o); end
    reset = 1'b1;
    step();
    tests++; if (done_o !== '0) begin fails++; $display("FAIL midreset_done got %b want 0", done_o); end
    tests++; if (tx_send_o !== 1'b0) begin fails++; $display("FAIL midreset_tx_send got %b want 0", tx_send_o); end
    tests++; if (tx_data_o !== 8'h00) begin fails++; $display("FAIL midreset_tx_data got %h want 00", tx_data_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b want 0", busy_o); end
    tests++; if (active_id_o !== 2'd0) begin fails++; $display("FAIL midreset_active_id got %0d want 0", active_id_o); end
    tests++; if (timeout_err_o !== 1'b0) begin fails++; $display("FAIL midreset_timeout_err got %b want 0", timeout_err_o); end
    reset = 1'b0;
    req_i = '0;
    for (int k = 0; k < 8; k++) step();
    tests++; if (sent_bytes.size() != 1) begin fails++; $display("FAIL midreset_no_more_send got %0d sends want 1", sent_bytes.size()); end
    tests++; if (done_ids.size() != 0) begin fails++; $display("FAIL midreset_no_done got %0d dones want 0", done_ids.size()); end
    clear_logs();
    req_data_i = {w1, w0};
    req_i = 2'b11;
    for (int k = 0; k < 20 && sent_bytes.size() == 0; k++) step();
    tests++; if (sent_bytes.size() != 1 || sent_bytes[0] !== w0[7:0]) begin fails++; $display("FAIL midreset_restart_byte got %0d bytes want first %h", sent_bytes.size(), w0[7:0]); end
    tests++; if (active_id_o !== 2'd0) begin fails++; $display("FAIL midreset_restart_id got %0d want 0", active_id_o); end
    do_reset();
  endtask

  task automatic test_holdoff();
    logic [W-1:0] w;
    do_reset();
    busy_len = 3;
    w = W'($urandom) | 16'h0101;
    req_data_i[W-1:0] = w;
    req_i = 2'b01;
    step();
    req_data_i[W-1:0] = ~w;
    req_i = 2'b00;
    for (int k = 0; k < 300 && done_ids.size() == 0; k++) step();
    for (int k = 0; k < 30; k++) step();
    tests++; if (done_ids.size() != 1) begin fails++; $display("FAIL holdoff_done_count got %0d want 1", done_ids.size()); end
    tests++; if (sent_bytes.size() != 2) begin fails++; $display("FAIL holdoff_byte_count got %0d want 2", sent_bytes.size()); end
    if (sent_bytes.size() >= 2) begin
      tests++; if ({sent_bytes[1], sent_bytes[0]} !== w) begin fails++; $display("FAIL holdoff_word got %h want %h", {sent_bytes[1], sent_bytes[0]}, w); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] words[NR][4];
    int           nw[NR], left[NR], idx[NR];
    logic [7:0]   exp_b[$];
    int           exp_id[$];
    int           ptr, total, pick;
    for (int round = 0; round < 8; round++) begin
      do_reset();
      busy_len = $urandom_range(1, 6);
      exp_b.delete(); exp_id.delete();
      total = 0;
      for (int i = 0; i < NR; i++) begin
        nw[i] = $urandom_range(0, 3);
        left[i] = nw[i];
        idx[i] = 0;
        total += nw[i];
        for (int k = 0; k < 4; k++) words[i][k] = W'($urandom);
      end
      // Reference: every requester with words left is pending at each arbitration.
      ptr = 0;
      for (int n = 0; n < total; n++) begin
        pick = -1;
        for (int k = NR - 1; k >= 0; k--) if (left[(ptr + k) % NR] > 0) pick = (ptr + k) % NR;
        for (int b = 0; b < WB; b++) exp_b.push_back(byte_of(words[pick][nw[pick] - left[pick]], b));
        exp_id.push_back(pick);
        left[pick]--;
        ptr = (pick + 1) % NR;
      end
      for (int i = 0; i < NR; i++) begin
        req_data_i[i*W +: W] = words[i][0];
        req_i[i] = (nw[i] > 0);
      end
      for (int k = 0; k < 3000 && done_ids.size() < total; k++) begin
        step();
        for (int i = 0; i < NR; i++) begin
          if (done_o[i]) begin
            idx[i]++;
            if (idx[i] < nw[i]) req_data_i[i*W +: W] = words[i][idx[i]];
            else req_i[i] = 1'b0;
          end
        end
      end
      step(); step();
      tests++; if (done_ids.size() != total) begin fails++; $display("FAIL random%0d_done_count got %0d want %0d", round, done_ids.size(), total); end
      tests++; if (sent_bytes.size() != exp_b.size()) begin fails++; $display("FAIL random%0d_byte_count got %0d want %0d", round, sent_bytes.size(), exp_b.size()); end
      for (int i = 0; i < exp_b.size() && i < sent_bytes.size(); i++) begin
        tests++; if (sent_bytes[i] !== exp_b[i]) begin fails++; $display("FAIL random%0d_byte%0d got %h want %h", round, i, sent_bytes[i], exp_b[i]); end
      end
      for (int i = 0; i < exp_id.size() && i < done_ids.size(); i++) begin
        tests++; if (done_ids[i] != exp_id[i]) begin fails++; $display("FAIL random%0d_order%0d got %0d want %0d", round, i, done_ids[i], exp_id[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_holdoff();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among NUM_REQ requesters. Typical requesters are the sum sender, a status reporter and a command echo. Each requester hands over one WORD_BYTES-byte word. The arbiter picks requesters round-robin, then sends the word byte by byte, LSB first, using the tx_send/tx_busy handshake instead of a fixed delay. It sits between the mode/send FSMs and the UART TX core.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
WORD_BYTES, 2, bytes per word (1..4); word width W = 8*WORD_BYTES
START_TIMEOUT, 100, max cycles to wait for tx_busy to rise after tx_send

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request level; held high until own done pulse
req_data  in  NUM_REQ*W  word of requester i at bits [i*W +: W]
done  out  NUM_REQ  one-cycle pulse: requester i's word fully sent
tx_busy  in  1  UART TX busy flag
tx_send  out  1  one-cycle start strobe to UART TX
tx_data  out  8  byte to UART TX, registered
busy  out  1  high whenever state != IDLE
active_id  out  2  index of granted requester (valid while busy)
timeout_err  out  1  sticky; set when tx_busy fails to rise in time

Behaviour:
- Reset values: state=IDLE, done=0, tx_send=0, tx_data=0, busy=0, active_id=0, timeout_err=0, rr_ptr=0, byte_idx=0, timer=0.
- rr_ptr is the highest-priority index. Requesters are searched in order rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
- IDLE, at least one req high:
  - grant the first requester found from rr_ptr; active_id <= winner;
  - latch its req_data into shift word; byte_idx <= 0; go to SEND.
- SEND:
  - tx_send=1 for exactly this cycle; tx_data already holds byte[byte_idx];
  - timer <= 0; go to WAIT_START.
- tx_data loading: tx_data is loaded from the latched word on the IDLE->SEND and BYTE_DONE->SEND transitions, so it is stable in the SEND cycle.
- WAIT_START:
  - tx_busy=1: go to WAIT_DONE.
  - otherwise, timer==START_TIMEOUT-1: timeout_err <= 1, go to BYTE_DONE (byte counted as sent).
  - otherwise timer++.
- WAIT_DONE: tx_busy=0, go to BYTE_DONE. No timeout in this state.
- BYTE_DONE:
  - byte_idx==WORD_BYTES-1: done[active_id]=1 for this cycle; rr_ptr <= (active_id+1) mod NUM_REQ; go to IDLE.
  - otherwise: byte_idx++, load next byte into tx_data, go to SEND.
- Latency (ideal UART, busy rises 1 cycle after strobe):
  - req high in IDLE at cycle 0 -> tx_send at cycle 1.
  - Inter-byte gap: tx_busy fall -> BYTE_DONE next cycle -> next tx_send the cycle after.
- Grant timing:
  - req is sampled only in IDLE. Dropping req mid-word does not abort the word.
  - req_data changes after grant are ignored.
- Fairness: a requester that keeps req high after its done pulse loses priority to any other pending requester at the next IDLE.
- Back-to-back: a requester re-requesting alone is granted on the cycle after returning to IDLE.
- tx_busy already high on entry to WAIT_START passes straight to WAIT_DONE. The UART core must not report a stale busy.
- Mid-operation reset: abort immediately; no done pulse, no further tx_send; all state returns to reset values, including timeout_err and rr_ptr.
- Unused active_id bits (NUM_REQ<4) are 0.

Test Plan:
- Single word: req[0]=1, word=16'hA55A, UART model raises busy 1 cycle after strobe and holds it 10 cycles -> tx_send twice with tx_data 8'h5A then 8'hA5, then done[0] pulses once, then busy=0.
- Contention: req=2'b11 in same cycle after reset, words 16'h1111 and 16'h2222 -> bytes 11,11 then 22,22; done[0] precedes done[1]. Requester 0 re-requests immediately -> requester 1 is still served before requester 0's second word.
- Timeout: model never asserts tx_busy -> each byte advances after exactly START_TIMEOUT cycles in WAIT_START; timeout_err=1 and stays set; done[0] still pulses.
- Reset mid-word: assert reset during WAIT_DONE of byte 0 -> next cycle all outputs are 0; no done pulse; a new request afterwards starts again from byte 0 of requester 0's priority.
- Hold-off: change req_data and drop req in the cycle after grant -> the originally latched word is transmitted intact; no re-grant without a new req.
